// File: rtl/leb128_if.sv
// leb128_if: value-in / byte-out handshake bundle for leb128_encoder
interface leb128_if;
  logic [63:0] in_data;
  logic        in_signed;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [3:0]  out_index;
  logic        busy;
  modport master (
    output in_data, in_signed, in_valid, out_ready,
    input  in_ready, out_byte, out_valid, out_last, out_index, busy
  );
  modport slave (
    input  in_data, in_signed, in_valid, out_ready,
    output in_ready, out_byte, out_valid, out_last, out_index, busy
  );
endinterface

// File: rtl/leb128_encoder.sv
// leb128_encoder: streaming unsigned/signed LEB128 encoder, one byte per cycle
// Signed (sLEB128) support is built only when LEB128_SIGNED_EN is defined.
module leb128_encoder #(
  parameter int WIDTH = 64
) (
  input  logic     clk,
  input  logic     reset,
  leb128_if.slave  bus
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t      state_q, state_d;
  logic [63:0] v_q, v_d;
  logic [3:0]  idx_q, idx_d;
  logic [63:0] rest, in_ext;
  logic        last, accept, advance, sx;
`ifdef LEB128_SIGNED_EN
  logic        sgn_q, sgn_d;
  always_comb begin
    sx     = bus.in_signed;
    sgn_d  = accept ? bus.in_signed : sgn_q;
    rest   = sgn_q ? 64'($signed(v_q) >>> 7) : v_q >> 7;
    last   = sgn_q ? ((rest == '0 && !v_q[6]) || (rest == '1 && v_q[6])) : rest == '0;
  end
  always_ff @(posedge clk)
    sgn_q <= reset ? 1'b0 : sgn_d;
`else
  always_comb begin
    sx   = 1'b0;
    rest = v_q >> 7;
    last = rest == '0;
  end
`endif
  always_comb begin
    in_ext        = (WIDTH == 32) ? {{32{sx & bus.in_data[31]}}, bus.in_data[31:0]} : bus.in_data;
    bus.busy      = state_q == EMIT;
    bus.out_valid = bus.busy;
    bus.out_last  = bus.busy && last;
    bus.out_byte  = bus.busy ? {~last, v_q[6:0]} : 8'h00;
    bus.out_index = idx_q;
    advance       = bus.busy && bus.out_ready;
    bus.in_ready  = (state_q == IDLE) || (advance && last);
    accept        = bus.in_valid && bus.in_ready;
    state_d       = accept ? EMIT : (advance && last) ? IDLE : state_q;
    v_d           = accept ? in_ext : (advance && !last) ? rest : v_q;
    idx_d         = accept ? 4'd0 : (advance && !last) ? idx_q + 4'd1 : idx_q;
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
    v_q     <= reset ? '0 : v_d;
    idx_q   <= reset ? '0 : idx_d;
  end
endmodule

// File: doc/leb128_encoder.md
# leb128_encoder

Streaming LEB128 encoder: accepts one integer per handshake and emits its unsigned or signed LEB128 encoding one byte per cycle. It is the write-side counterpart of the CPU's immediate-operand LEB128 decoder. It sits between result/constant producers and the bytecode image builder or host link, so values leaving the core use the same encoding that the core's fetch path consumes.

## Interface
- `WIDTH`, 64: input integer width; legal values are 32 and 64. Only the low `WIDTH` bits of `in_data` are used.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  64  value to encode.
- `in_signed`  in  1  1 selects signed LEB128 (sLEB128); 0 selects unsigned LEB128.
- `in_valid`  in  1  input value offered.
- `in_ready`  out  1  encoder can accept a value this cycle.
- `out_byte`  out  8  encoded byte.
- `out_valid`  out  1  `out_byte` is valid.
- `out_ready`  in  1  downstream accepts `out_byte`.
- `out_last`  out  1  `out_byte` is the final byte of the current value.
- `out_index`  out  4  zero-based position of `out_byte` within the current value.
- `busy`  out  1  a value is being emitted.

## Operation
- States:
  - IDLE: no value in progress. `out_valid`=0, `in_ready`=1.
  - EMIT: a registered byte is presented on `out_byte`.
- Accept: a value is accepted when `in_valid && in_ready`.
  - The low `WIDTH` bits are latched into a 64-bit shift register.
  - For `WIDTH`=32, the latched value is sign-extended when signed and zero-extended when unsigned.
  - The `in_signed` mode is latched at accept time.
  - State goes to EMIT with `out_index`=0.
- Byte formation, with `v` = the current shift register:
  - Unsigned: `rest = v >> 7` (logical shift); the byte is last when `rest == 0`.
  - Signed: `rest = v >>> 7` (arithmetic shift); the byte is last when (`rest == 0` and `v[6] == 0`) or (`rest == all-ones` and `v[6] == 1`).
  - `out_byte = {~last, v[6:0]}`; `out_last = last`.
- Advance: on `out_valid && out_ready`:
  - If the byte is not last: `v <= rest`, `out_index` increments.
  - If the byte is last: return to IDLE, unless a new value is accepted in the same cycle (see below).
- Back-to-back: `in_ready = (state == IDLE) || (out_valid && out_ready && out_last)`.
  - A value accepted on the cycle the previous last byte is consumed starts emitting on the next cycle, with no bubble.
- Maximum length:
  - 10 bytes for `WIDTH`=64; 5 bytes for `WIDTH`=32.
  - `out_index` never exceeds 9 or 4 respectively.
- `busy` = (state == EMIT).

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_last`=0, `out_byte`=0x00, `out_index`=0, `busy`=0, `in_ready`=1.
- Latency: the first byte appears on `out_valid` the cycle after the accept.
- Throughput: one byte per cycle while `out_ready`=1. A value of N bytes occupies exactly N cycles of `out_valid`.
- Backpressure: while `out_valid && !out_ready`, the outputs `out_byte`, `out_last` and `out_index` hold stable. `out_valid` never drops without a handshake.
- `in_ready` is combinational from state and `out_ready`. No other combinational input-to-output paths exist.
- `in_valid` while busy and not on the last-byte handshake: the value is not accepted and the encoder state is unchanged.
- Reset during EMIT: the encoding in progress is aborted. The next cycle shows reset values and no `out_last` is ever produced for the aborted value.

## Configuration
- `LEB128_SIGNED_EN` defined: signed encoding is supported as described above.
- `LEB128_SIGNED_EN` undefined:
  - `in_signed` is ignored and all values are encoded unsigned.
  - The arithmetic-shift and sign-termination logic is not synthesized.
  - `WIDTH`=32 inputs are always zero-extended.

## Test plan
- Unsigned 0 → one byte 0x00, `out_last`=1, `out_index`=0, `busy` drops the next cycle.
- Unsigned 624485 → 0xE5, 0x8E, 0x26, with `out_last` only on 0x26; repeat with `out_ready` low for 3 cycles after the first byte → 0x8E held stable throughout the stall.
- Unsigned 0xFFFFFFFFFFFFFFFF, `WIDTH`=64 → nine 0xFF bytes then 0x01, with `out_index` running 0..9; the same value with `WIDTH`=32 → 0xFF ×4 then 0x0F.
- Signed −123456 → 0xC0, 0xBB, 0x78; signed −1 → 0x7F; signed 64 → 0xC0, 0x00; signed −64 → 0x40. Without `LEB128_SIGNED_EN`, signed −1 (64-bit) → nine 0xFF bytes then 0x01.
- Back-to-back: unsigned 300 and then unsigned 5 held on `in_valid` with `out_ready`=1 → 0xAC, 0x02, 0x05 on consecutive cycles, and `in_ready`=1 on the 0x02 cycle.
- Reset asserted during the second byte of 624485 → the next cycle shows `out_valid`=0 and `busy`=0; afterwards unsigned 1 → a single byte 0x01.
